// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension pipeline stage:
// immediate format codes, legal XLEN values and buffer occupancy states.
package imm_extend_pipe_pkg;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6,
        IMM_RSVD = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extraction and extension from instruction bits [31:7].
// Index n of inst corresponds to instruction bit n+7.
module imm_extend_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     inst,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] v32;
    logic        sext;

    always_comb begin
        v32     = 32'd0;
        sext    = 1'b0;
        illegal = 1'b0;
        case (imm_type_e'(imm_type))
            IMM_I: begin
                v32  = {{20{inst[24]}}, inst[24:13]};
                sext = 1'b1;
            end
            IMM_S: begin
                v32  = {{20{inst[24]}}, inst[24:18], inst[4:0]};
                sext = 1'b1;
            end
            IMM_B: begin
                v32  = {{20{inst[24]}}, inst[0], inst[23:18], inst[4:1], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                // sign bit already sits at bit 31; widening to 64 extends it
                v32  = {inst[24:5], 12'd0};
                sext = 1'b1;
            end
            IMM_J: begin
                v32  = {{12{inst[24]}}, inst[12:5], inst[13], inst[23:14], 1'b0};
                sext = 1'b1;
            end
            IMM_Z: begin
                v32 = {27'd0, inst[12:8]};
            end
            IMM_RSVD: begin
                illegal = 1'b1;
            end
            default: begin
                v32 = 32'd0;
            end
        endcase
        imm = sext ? XLEN'($signed(v32)) : XLEN'(v32);
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: output register plus one skid register, ready/valid
// handshake on both sides and an accepted-transfer counter.
//
// state     | meaning
// OCC_EMPTY | O and K empty
// OCC_ONE   | O holds an entry, K empty
// OCC_FULL  | O and K hold entries, upstream stalled
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      inst,
    input  logic [2:0]       imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] acc_cnt
);

    occ_state_e       state;
    logic [XLEN-1:0]  ext_imm;
    logic             ext_ill;
    logic [XLEN-1:0]  k_imm;
    logic [TAG_W-1:0] k_tag;
    logic             k_ill;
    logic             in_fire;
    logic             out_fire;

    imm_extend_core #(.XLEN(XLEN)) u_core (
        .inst     (inst),
        .imm_type (imm_type),
        .imm      (ext_imm),
        .illegal  (ext_ill)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // in_ready is a register equal to !K.valid, so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OCC_EMPTY;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            imm         <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            k_imm       <= '0;
            k_tag       <= '0;
            k_ill       <= 1'b0;
            acc_cnt     <= '0;
        end else if (flush) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (in_fire) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            case (state)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        imm         <= ext_imm;
                        out_tag     <= in_tag;
                        out_illegal <= ext_ill;
                        out_valid   <= 1'b1;
                        state       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        imm         <= ext_imm;
                        out_tag     <= in_tag;
                        out_illegal <= ext_ill;
                    end else if (in_fire) begin
                        k_imm    <= ext_imm;
                        k_tag    <= in_tag;
                        k_ill    <= ext_ill;
                        in_ready <= 1'b0;
                        state    <= OCC_FULL;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        imm         <= k_imm;
                        out_tag     <= k_tag;
                        out_illegal <= k_ill;
                        in_ready    <= 1'b1;
                        state       <= OCC_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
